// File: rtl/popcount_pkg.sv
// Shared types and constants for the sequential population counter.
//   state_t    : controller states
//   MODE_ONES  : count 1 bits of the captured word
//   MODE_ZEROS : count 0 bits (word is inverted on capture)
package popcount_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic MODE_ONES  = 1'b0;
  localparam logic MODE_ZEROS = 1'b1;

endpackage

// File: rtl/popcount_datapath.sv
// Shift register and bit counter for popcount_seq.
// Ports:
//   CLOCK_50, reset : clock and asynchronous active-low reset
//   load            : capture data_in (inverted when mode selects zeros)
//   shift           : add A[0] to result and shift A right by one
//   clr             : clear result
//   mode, data_in   : operand, only used on load
//   a_zero          : A holds no more 1 bits
//   result          : running count
module popcount_datapath
  import popcount_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             clr,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             a_zero,
  output logic [CNT_W-1:0] result
);

  logic [WIDTH-1:0] a;

  // Operand register: capture on load, otherwise drain one bit per shift.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      a <= '0;
    end else if (load) begin
      a <= (mode == MODE_ZEROS) ? ~data_in : data_in;
    end else if (shift) begin
      a <= a >> 1;
    end
  end

  // Count register: CNT_W is wide enough that WIDTH increments cannot wrap.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      result <= '0;
    end else if (clr) begin
      result <= '0;
    end else if (shift) begin
      result <= result + CNT_W'(a[0]);
    end
  end

  assign a_zero = ~|a;

endmodule

// File: rtl/popcount_seq.sv
// Sequential population counter with start/done handshake.
// Counts 1 bits (mode=0) or 0 bits (mode=1) of data_in, one bit per clock,
// finishing early once the remaining shifted word is all zero.
// Ports:
//   CLOCK_50 : clock
//   reset    : asynchronous active-low reset
//   start    : level request, accepted only when idle
//   mode     : 0 = count ones, 1 = count zeros (sampled with start)
//   data_in  : word to count (sampled with start)
//   busy     : counting in progress
//   done     : result valid, held until start drops
//   result   : count, held until the next accepted start
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result
);

  state_t state;
  logic   a_zero;
  logic   load_c;
  logic   shift_c;

  // Datapath strobes decoded from the current state.
  assign load_c  = (state == S_IDLE) && start;
  assign shift_c = (state == S_COUNT) && !a_zero;

  // Controller; busy/done are registered alongside the state they decode.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_COUNT;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        S_COUNT: begin
          if (a_zero) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          // A held start must drop before a new operation is accepted.
          if (!start) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  popcount_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_datapath (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .load     (load_c),
    .shift    (shift_c),
    .clr      (load_c),
    .mode     (mode),
    .data_in  (data_in),
    .a_zero   (a_zero),
    .result   (result)
  );

endmodule

// File: doc/popcount_seq.md
# popcount_seq

Sequential parametrised population counter with a start/done handshake. It captures a WIDTH-bit word and counts either its 1 bits or its 0 bits. Counting is one bit per clock by right-shifting, and it stops early once the remaining bits are all zero. It sits beside the board top level as a reusable controller/datapath pair, driven from switches or from another FSM.

## Interface
Parameters:
- WIDTH, 8, width of the input word (≥2)
- CNT_W, $clog2(WIDTH+1), width of the result (derived; do not override)

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- start  in  1  level request; sampled only in S_IDLE
- mode  in  1  0 = count 1 bits, 1 = count 0 bits; sampled with start
- data_in  in  WIDTH  word to count; sampled with start
- busy  out  1  high in S_COUNT
- done  out  1  high in S_DONE
- result  out  CNT_W  count; valid while done high, held until next accepted start

## Operation
- States: S_IDLE, S_COUNT, S_DONE.
- S_IDLE, start=1:
  - A <= mode ? ~data_in : data_in
  - result <= 0
  - go to S_COUNT
- S_IDLE, start=0: hold; result keeps its last value.
- S_COUNT, A == 0: go to S_DONE; A and result unchanged.
- S_COUNT, A != 0:
  - result <= result + A[0]
  - A <= A >> 1 (zero fill)
  - stay in S_COUNT
- S_DONE, start=1: stay; done high, result held.
- S_DONE, start=0: go to S_IDLE.
- Width rules:
  - result cannot overflow because CNT_W holds WIDTH.
  - The increment is zero-extended to CNT_W.
- Operand capture:
  - data_in and mode are ignored outside the accepting S_IDLE edge.
  - Changes during S_COUNT or S_DONE have no effect.
- start during S_COUNT is ignored. There is no abort; abort only by reset.
- A start held high through S_DONE does not retrigger. A new operation requires start=0 (back to S_IDLE) and then start=1.
- Reset asserted at any time, including mid-count, takes effect immediately without waiting for a clock edge:
  - state = S_IDLE, A = 0, result = 0, busy = 0, done = 0
  - Counting resumes only after reset deasserts and a fresh start arrives.

## Timing
- Reset values: busy=0, done=0, result=0, state S_IDLE.
- Latency is defined from the edge E0 that accepts start in S_IDLE to the edge after which done=1.
  - Let k be the index of the highest 1 in the captured A, with k = -1 when A = 0.
  - Latency = k+2 edges.
  - Maximum latency = WIDTH+1 edges; minimum = 1 edge (captured A = 0).
- busy is high for exactly k+2 cycles, directly followed by done.
- busy and done are Moore outputs decoded from state, registered-state only, with no combinational path from inputs.
- busy and done are never high together.
- result changes only:
  - on the accepting edge (cleared to 0)
  - on S_COUNT edges with A[0]=1 (+1)
- result is stable from done rising until the next accepting edge.

## Structure
- Package popcount_pkg:
  - state typedef: enum logic [1:0] {S_IDLE, S_COUNT, S_DONE}
  - mode constants MODE_ONES = 1'b0 and MODE_ZEROS = 1'b1
- Top popcount_seq contains the FSM and the status outputs.
- One sub-module, popcount_datapath, holds:
  - the A shift register and the result counter
  - control inputs load, shift, clr from the FSM
  - status output a_zero (= ~|A) back to the FSM
- The datapath uses the same CLOCK_50/reset pair as the top.

## Test plan
- Ones count, WIDTH=8: mode=0, data_in=8'b1011_0010, start 0→1 -> busy for 9 cycles, then done=1, result=4.
- Zero word: WIDTH=8, mode=0, data_in=8'h00 -> done after 1 edge, result=0, busy high 1 cycle. Also mode=1, data_in=8'hFF -> same result.
- Zeros count: mode=1, data_in=8'h0F -> captured 8'hF0, latency 9 edges, result=4. Toggle data_in and mode every cycle during S_COUNT -> result still 4.
- Handshake: hold start=1 for 20 cycles after done -> done stays 1 and result stays 4 with no recount. Then:
  - drop start -> S_IDLE next edge, done=0, result still 4.
  - raise start with data_in=8'h01 -> result=1 after 2 edges.
- Reset mid-operation: data_in=8'hFF, assert reset asynchronously 3 cycles into S_COUNT -> result=0, busy=0, done=0 immediately. After release, no activity until start rises.
- Full width, WIDTH=16: data_in=16'hFFFF, mode=0 -> CNT_W=5, result=16, latency 17 edges. Then data_in=16'h8000 -> result=1, latency 17 edges.
